// File: rtl/jelly3_bram_pkg.sv
// Shared definitions for the jelly3 BRAM family: read-mode enum, byte-lane
// merge and per-lane even parity. The accessor side uses the same helpers,
// so both functions work on fixed maximum widths. Callers zero-extend their
// operands and truncate the result to their own width.
package jelly3_bram_pkg;

   typedef enum logic {
      READ_FIRST,
      WRITE_FIRST
   } read_mode_t;

   localparam int MAX_DATA_BITS = 512;
   localparam int MAX_WE_BITS   = 64;

   // Lanes with we set take new_word and the others keep old_word. A lane is
   // byte_bits wide, so byte_bits = 1 gives a plain bit-mask merge.
   function automatic logic [MAX_DATA_BITS-1:0] merge_bytes(
      input logic [MAX_DATA_BITS-1:0] old_word,
      input logic [MAX_DATA_BITS-1:0] new_word,
      input logic [MAX_WE_BITS-1:0]   we,
      input int                       byte_bits = 8
   );
      logic [MAX_DATA_BITS-1:0] result;
      int lane;
      result = old_word;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         lane = i / byte_bits;
         if (lane < MAX_WE_BITS) begin
            if (we[lane]) begin
               result[i] = new_word[i];
            end
         end
      end
      return result;
   endfunction

   // Each lane gets one even-parity bit, which is the XOR of all the bits in
   // that lane.
   function automatic logic [MAX_WE_BITS-1:0] lane_parity(
      input logic [MAX_DATA_BITS-1:0] data,
      input int                       byte_bits = 8
   );
      logic [MAX_WE_BITS-1:0] p;
      int lane;
      p = '0;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         lane = i / byte_bits;
         if (lane < MAX_WE_BITS) begin
            p[lane] = p[lane] ^ data[i];
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/jelly3_bram_read_pipe.sv
// A read-data register chain of LATENCY stages. Stage 0 captures din and
// stage i captures stage i-1. Each stage has its own enable and holds its
// value while that enable is low. An async active-low reset clears every
// stage.
module jelly3_bram_read_pipe #(
   parameter int LATENCY = 2,
   parameter int WIDTH   = 32
) (
   input  logic               aresetn,
   input  logic               aclk,
   input  logic [LATENCY-1:0] en,
   input  logic [WIDTH-1:0]   din,
   output logic [WIDTH-1:0]   dout
);

   logic [WIDTH-1:0] stage [LATENCY];

   // Each stage advances only when its own enable is high, so a stall in one stage leaves the others free
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         for (int i = 0; i < LATENCY; i++) begin
            stage[i] <= '0;
         end
      end else begin
         if (en[0]) begin
            stage[0] <= din;
         end
         for (int i = 1; i < LATENCY; i++) begin
            if (en[i]) begin
               stage[i] <= stage[i-1];
            end
         end
      end
   end

   assign dout = stage[LATENCY-1];

endmodule

// File: rtl/jelly3_bram_dualport_ram.sv
// True-dual-port block RAM. Port A is driven by the AXI4-Lite BRAM accessor
// and port B by fabric logic. Both ports return data after RLATENCY enabled
// pipeline stages.
// When both ports write the same word in the same cycle, A owns the lanes it
// writes and B keeps the lanes that only it writes. A reader that hits a word
// being written by the other port sees the old contents.
// The array has no reset. INIT_ZERO=1 relies on the zero-initialised
// block RAM contents of the target.
// Optional feature: define JELLY3_BRAM_DUALPORT_RAM_PARITY_EN to store one
// even-parity bit per lane and report a_perr/b_perr alongside rdata.
module jelly3_bram_dualport_ram
   import jelly3_bram_pkg::*;
#(
   parameter int    RLATENCY  = 2,
   parameter int    ADDR_BITS = 10,
   parameter int    DATA_BITS = 32,
   parameter int    BYTE_BITS = 8,
   parameter int    WE_BITS   = DATA_BITS / BYTE_BITS,
   parameter string READ_MODE = "READ_FIRST",
   parameter int    INIT_ZERO = 1
) (
   input  logic                 aresetn,
   input  logic                 aclk,
   input  logic [RLATENCY-1:0]  a_en,
   input  logic [WE_BITS-1:0]   a_we,
   input  logic [ADDR_BITS-1:0] a_addr,
   input  logic [DATA_BITS-1:0] a_wdata,
   output logic [DATA_BITS-1:0] a_rdata,
   input  logic [RLATENCY-1:0]  b_en,
   input  logic [WE_BITS-1:0]   b_we,
   input  logic [ADDR_BITS-1:0] b_addr,
   input  logic [DATA_BITS-1:0] b_wdata,
   output logic [DATA_BITS-1:0] b_rdata,
   output logic                 collision
`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
   ,
   input  logic [WE_BITS-1:0]   a_force_perr_lane,
   input  logic [WE_BITS-1:0]   b_force_perr_lane,
   output logic [WE_BITS-1:0]   a_perr,
   output logic [WE_BITS-1:0]   b_perr
`endif
);

   localparam int         DEPTH = 2 ** ADDR_BITS;
   localparam read_mode_t MODE  = (READ_MODE == "WRITE_FIRST") ? WRITE_FIRST : READ_FIRST;

   if (RLATENCY < 1 || RLATENCY > 4 || (DATA_BITS % BYTE_BITS) != 0 ||
       DATA_BITS > MAX_DATA_BITS || WE_BITS > MAX_WE_BITS ||
       (INIT_ZERO != 0 && INIT_ZERO != 1)) begin : g_param_check
      $error("jelly3_bram_dualport_ram: unsupported parameter combination");
   end

   function automatic logic [DATA_BITS-1:0] merge_word(
      input logic [DATA_BITS-1:0] old_word,
      input logic [DATA_BITS-1:0] new_word,
      input logic [WE_BITS-1:0]   we
   );
      return DATA_BITS'(merge_bytes(MAX_DATA_BITS'(old_word), MAX_DATA_BITS'(new_word),
                                    MAX_WE_BITS'(we), BYTE_BITS));
   endfunction

   logic [DATA_BITS-1:0] mem [DEPTH];

   logic                 a_wr;
   logic                 b_wr;
   logic                 same_addr;
   logic [DATA_BITS-1:0] a_old;
   logic [DATA_BITS-1:0] b_old;
   logic [DATA_BITS-1:0] a_self;
   logic [DATA_BITS-1:0] b_word;
   logic [DATA_BITS-1:0] a_word;
   logic [DATA_BITS-1:0] a_read;
   logic [DATA_BITS-1:0] b_read;

   assign a_wr      = a_en[0] && (|a_we);
   assign b_wr      = b_en[0] && (|b_we);
   assign same_addr = (a_addr == b_addr);
   assign a_old     = mem[a_addr];
   assign b_old     = mem[b_addr];

   // On a shared address, A's merge is layered on top of B's merge, so A wins the lanes it writes.
   assign a_self = merge_word(a_old, a_wdata, a_we);
   assign b_word = merge_word(b_old, b_wdata, b_we);
   assign a_word = (b_wr && same_addr) ? merge_word(b_word, a_wdata, a_we) : a_self;

   // WRITE_FIRST shows only the port's own write. The other port's write is never visible in the same cycle.
   assign a_read = (MODE == WRITE_FIRST && a_wr) ? a_self : a_old;
   assign b_read = (MODE == WRITE_FIRST && b_wr) ? b_word : b_old;

   // B commits first so that A's word, which already folds in B's lanes on a shared address, lands last.
   always_ff @(posedge aclk) begin
      if (b_wr) begin
         mem[b_addr] <= b_word;
      end
      if (a_wr) begin
         mem[a_addr] <= a_word;
      end
   end

   jelly3_bram_read_pipe #(
      .LATENCY (RLATENCY),
      .WIDTH   (DATA_BITS)
   ) u_a_pipe (
      .aresetn (aresetn),
      .aclk    (aclk),
      .en      (a_en),
      .din     (a_read),
      .dout    (a_rdata)
   );

   jelly3_bram_read_pipe #(
      .LATENCY (RLATENCY),
      .WIDTH   (DATA_BITS)
   ) u_b_pipe (
      .aresetn (aresetn),
      .aclk    (aclk),
      .en      (b_en),
      .din     (b_read),
      .dout    (b_rdata)
   );

   // Flag for one cycle when both ports hit the same word in the same cycle and at least one of them writes.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         collision <= 1'b0;
      end else begin
         collision <= a_en[0] && b_en[0] && same_addr && (a_wr || b_wr);
      end
   end

`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
   function automatic logic [WE_BITS-1:0] parity_of(input logic [DATA_BITS-1:0] data);
      return WE_BITS'(lane_parity(MAX_DATA_BITS'(data), BYTE_BITS));
   endfunction

   function automatic logic [WE_BITS-1:0] merge_par(
      input logic [WE_BITS-1:0] old_par,
      input logic [WE_BITS-1:0] new_par,
      input logic [WE_BITS-1:0] we
   );
      return WE_BITS'(merge_bytes(MAX_DATA_BITS'(old_par), MAX_DATA_BITS'(new_par),
                                  MAX_WE_BITS'(we), 1));
   endfunction

   logic [WE_BITS-1:0] par_mem [DEPTH];

   logic [WE_BITS-1:0] a_par_new;
   logic [WE_BITS-1:0] b_par_new;
   logic [WE_BITS-1:0] a_par_old;
   logic [WE_BITS-1:0] b_par_old;
   logic [WE_BITS-1:0] a_par_self;
   logic [WE_BITS-1:0] b_par_word;
   logic [WE_BITS-1:0] a_par_word;
   logic [WE_BITS-1:0] a_par_read;
   logic [WE_BITS-1:0] b_par_read;
   logic [WE_BITS-1:0] a_par_out;
   logic [WE_BITS-1:0] b_par_out;

   // Forced lanes store inverted parity, so a later read of that word reports an error on those lanes.
   assign a_par_new  = parity_of(a_wdata) ^ a_force_perr_lane;
   assign b_par_new  = parity_of(b_wdata) ^ b_force_perr_lane;
   assign a_par_old  = par_mem[a_addr];
   assign b_par_old  = par_mem[b_addr];
   assign a_par_self = merge_par(a_par_old, a_par_new, a_we);
   assign b_par_word = merge_par(b_par_old, b_par_new, b_we);
   assign a_par_word = (b_wr && same_addr) ? merge_par(b_par_word, a_par_new, a_we) : a_par_self;
   assign a_par_read = (MODE == WRITE_FIRST && a_wr) ? a_par_self : a_par_old;
   assign b_par_read = (MODE == WRITE_FIRST && b_wr) ? b_par_word : b_par_old;

   // The parity array follows the same commit order as the data array, so it resolves collisions the same way.
   always_ff @(posedge aclk) begin
      if (b_wr) begin
         par_mem[b_addr] <= b_par_word;
      end
      if (a_wr) begin
         par_mem[a_addr] <= a_par_word;
      end
   end

   jelly3_bram_read_pipe #(
      .LATENCY (RLATENCY),
      .WIDTH   (WE_BITS)
   ) u_a_par_pipe (
      .aresetn (aresetn),
      .aclk    (aclk),
      .en      (a_en),
      .din     (a_par_read),
      .dout    (a_par_out)
   );

   jelly3_bram_read_pipe #(
      .LATENCY (RLATENCY),
      .WIDTH   (WE_BITS)
   ) u_b_par_pipe (
      .aresetn (aresetn),
      .aclk    (aclk),
      .en      (b_en),
      .din     (b_par_read),
      .dout    (b_par_out)
   );

   assign a_perr = parity_of(a_rdata) ^ a_par_out;
   assign b_perr = parity_of(b_rdata) ^ b_par_out;
`else
   // This build has no parity storage, and the array is exactly DATA_BITS wide.
`endif

endmodule

// File: tb/tb_jelly3_bram_dualport_ram.sv
// Testbench for jelly3_bram_dualport_ram. It runs a READ_FIRST instance and a
// WRITE_FIRST instance side by side on the same stimulus. A behavioural
// memory model computes each read's expected value, which goes into a
// scoreboard queue at issue time and is popped when the read emerges.
// Define JELLY3_BRAM_DUALPORT_RAM_PARITY_EN to also exercise the parity
// outputs.
module tb_jelly3_bram_dualport_ram;

   typedef struct {
      logic        port;
      logic [31:0] rf;
      logic [31:0] wf;
   } sb_entry_t;

   logic        aclk;
   logic        aresetn;
   logic [1:0]  a_en;
   logic [3:0]  a_we;
   logic [9:0]  a_addr;
   logic [31:0] a_wdata;
   logic [1:0]  b_en;
   logic [3:0]  b_we;
   logic [9:0]  b_addr;
   logic [31:0] b_wdata;
   logic [31:0] rf_a_rdata;
   logic [31:0] rf_b_rdata;
   logic        rf_collision;
   logic [31:0] wf_a_rdata;
   logic [31:0] wf_b_rdata;
   logic        wf_collision;
`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
   logic [3:0]  a_force;
   logic [3:0]  b_force;
   logic [3:0]  rf_a_perr;
   logic [3:0]  rf_b_perr;
   logic [3:0]  wf_a_perr;
   logic [3:0]  wf_b_perr;
`endif

   logic [31:0] model [1024];
   sb_entry_t   sb [$];
   int          checks;
   int          errors;

   jelly3_bram_dualport_ram #(
      .RLATENCY  (2),
      .READ_MODE ("READ_FIRST")
   ) dut_rf (
      .aresetn   (aresetn),
      .aclk      (aclk),
      .a_en      (a_en),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_rdata   (rf_a_rdata),
      .b_en      (b_en),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_rdata   (rf_b_rdata),
      .collision (rf_collision)
`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
      ,
      .a_force_perr_lane (a_force),
      .b_force_perr_lane (b_force),
      .a_perr            (rf_a_perr),
      .b_perr            (rf_b_perr)
`endif
   );

   jelly3_bram_dualport_ram #(
      .RLATENCY  (2),
      .READ_MODE ("WRITE_FIRST")
   ) dut_wf (
      .aresetn   (aresetn),
      .aclk      (aclk),
      .a_en      (a_en),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_rdata   (wf_a_rdata),
      .b_en      (b_en),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_rdata   (wf_b_rdata),
      .collision (wf_collision)
`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
      ,
      .a_force_perr_lane (a_force),
      .b_force_perr_lane (b_force),
      .a_perr            (wf_a_perr),
      .b_perr            (wf_b_perr)
`endif
   );

   // Free-running 100 MHz clock
   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   // Stop a runaway simulation
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish, required completion before 200000");
      $fatal(1, "[TB] watchdog expired");
   end

   function automatic logic [31:0] merge_model(input logic [31:0] old_word, input logic [31:0] new_word,
                                               input logic [3:0] we);
      logic [31:0] r;
      r = old_word;
      for (int k = 0; k < 4; k++) begin
         if (we[k]) r[k*8 +: 8] = new_word[k*8 +: 8];
      end
      return r;
   endfunction

   // Drive one cycle on both ports, queue the expected read data, then update the model (B first, A wins).
   task automatic do_cycle(input logic [1:0] aen, input logic [3:0] awe, input logic [9:0] aaddr,
                           input logic [31:0] awd, input logic [1:0] ben, input logic [3:0] bwe,
                           input logic [9:0] baddr, input logic [31:0] bwd,
                           input logic push_a, input logic push_b);
      sb_entry_t e;
      a_en = aen; a_we = awe; a_addr = aaddr; a_wdata = awd;
      b_en = ben; b_we = bwe; b_addr = baddr; b_wdata = bwd;
      if (push_a) begin
         e.port = 1'b0;
         e.rf   = model[aaddr];
         e.wf   = (aen[0] && (|awe)) ? merge_model(model[aaddr], awd, awe) : model[aaddr];
         sb.push_back(e);
      end
      if (push_b) begin
         e.port = 1'b1;
         e.rf   = model[baddr];
         e.wf   = (ben[0] && (|bwe)) ? merge_model(model[baddr], bwd, bwe) : model[baddr];
         sb.push_back(e);
      end
      @(posedge aclk);
      #1;
      if (ben[0] && (|bwe)) model[baddr] = merge_model(model[baddr], bwd, bwe);
      if (aen[0] && (|awe)) model[aaddr] = merge_model(model[aaddr], awd, awe);
      a_en = 2'b10; a_we = '0;
      b_en = 2'b10; b_we = '0;
   endtask

   task automatic idle_cycle();
      do_cycle(2'b10, 4'h0, 10'h0, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      repeat (2) @(posedge aclk);
      #1;
      checks++;
      if (rf_a_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_a_rdata: got %h expected 0", rf_a_rdata); end
      checks++;
      if (rf_b_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_b_rdata: got %h expected 0", rf_b_rdata); end
      checks++;
      if (rf_collision !== 1'b0) begin errors++; $display("[TB] FAIL reset_collision: got %b expected 0", rf_collision); end
      checks++;
      if (wf_a_rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_wf_a_rdata: got %h expected 0", wf_a_rdata); end
      aresetn = 1'b1;
      idle_cycle();
   endtask

   task automatic test_write_read();
      sb_entry_t e;
      do_cycle(2'b11, 4'hF, 10'h010, 32'hDEADBEEF, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      do_cycle(2'b11, 4'h0, 10'h010, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0);
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_a_rdata !== e.rf) begin errors++; $display("[TB] FAIL write_read_rf: got %h expected %h", rf_a_rdata, e.rf); end
      checks++;
      if (wf_a_rdata !== e.wf) begin errors++; $display("[TB] FAIL write_read_wf: got %h expected %h", wf_a_rdata, e.wf); end
`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
      checks++;
      if (rf_a_perr !== 4'b0000) begin errors++; $display("[TB] FAIL clean_perr: got %b expected 0000", rf_a_perr); end
`endif
   endtask

   task automatic test_partial_write();
      sb_entry_t e;
      do_cycle(2'b11, 4'hF, 10'd5, 32'h11223344, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      do_cycle(2'b11, 4'b0101, 10'd5, 32'hAABBCCDD, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      do_cycle(2'b10, 4'h0, 10'h0, 32'h0, 2'b11, 4'h0, 10'd5, 32'h0, 1'b0, 1'b1);
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_b_rdata !== e.rf) begin errors++; $display("[TB] FAIL partial_rf: got %h expected %h", rf_b_rdata, e.rf); end
      checks++;
      if (wf_b_rdata !== e.wf) begin errors++; $display("[TB] FAIL partial_wf: got %h expected %h", wf_b_rdata, e.wf); end
   endtask

   task automatic test_collision();
      sb_entry_t e;
      do_cycle(2'b11, 4'b0011, 10'd7, 32'h0000AAAA, 2'b11, 4'b1111, 10'd7, 32'hBBBBBBBB, 1'b0, 1'b0);
      checks++;
      if (rf_collision !== 1'b1) begin errors++; $display("[TB] FAIL coll_ww_pulse: got %b expected 1", rf_collision); end
      do_cycle(2'b11, 4'h0, 10'd7, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0);
      checks++;
      if (rf_collision !== 1'b0) begin errors++; $display("[TB] FAIL coll_ww_single: got %b expected 0", rf_collision); end
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_a_rdata !== e.rf) begin errors++; $display("[TB] FAIL coll_ww_data: got %h expected %h", rf_a_rdata, e.rf); end
      // Port A writes the word while port B reads it: B must see the old word.
      do_cycle(2'b11, 4'hF, 10'd8, 32'h01020304, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      do_cycle(2'b11, 4'hF, 10'd8, 32'h55555555, 2'b11, 4'h0, 10'd8, 32'h0, 1'b0, 1'b1);
      checks++;
      if (rf_collision !== 1'b1) begin errors++; $display("[TB] FAIL coll_wr_pulse: got %b expected 1", rf_collision); end
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_b_rdata !== e.rf) begin errors++; $display("[TB] FAIL coll_wr_rf: got %h expected %h", rf_b_rdata, e.rf); end
      checks++;
      if (wf_b_rdata !== e.wf) begin errors++; $display("[TB] FAIL coll_wr_wf: got %h expected %h", wf_b_rdata, e.wf); end
      do_cycle(2'b11, 4'h0, 10'd8, 32'h0, 2'b11, 4'h0, 10'd8, 32'h0, 1'b0, 1'b0);
      checks++;
      if (rf_collision !== 1'b0) begin errors++; $display("[TB] FAIL coll_rr_none: got %b expected 0", rf_collision); end
      do_cycle(2'b11, 4'hF, 10'd9, 32'h1, 2'b11, 4'hF, 10'd10, 32'h2, 1'b0, 1'b0);
      checks++;
      if (rf_collision !== 1'b0) begin errors++; $display("[TB] FAIL coll_diff_addr: got %b expected 0", rf_collision); end
   endtask

   task automatic test_write_first();
      sb_entry_t e;
      do_cycle(2'b11, 4'hF, 10'd3, 32'hAAAAAAAA, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      do_cycle(2'b11, 4'hF, 10'd3, 32'h12345678, 2'b10, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0);
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_a_rdata !== e.rf) begin errors++; $display("[TB] FAIL rdw_full_rf: got %h expected %h", rf_a_rdata, e.rf); end
      checks++;
      if (wf_a_rdata !== e.wf) begin errors++; $display("[TB] FAIL rdw_full_wf: got %h expected %h", wf_a_rdata, e.wf); end
      do_cycle(2'b11, 4'b0011, 10'd3, 32'h0000FFFF, 2'b10, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0);
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_a_rdata !== e.rf) begin errors++; $display("[TB] FAIL rdw_part_rf: got %h expected %h", rf_a_rdata, e.rf); end
      checks++;
      if (wf_a_rdata !== e.wf) begin errors++; $display("[TB] FAIL rdw_part_wf: got %h expected %h", wf_a_rdata, e.wf); end
   endtask

   task automatic test_back_to_back();
      sb_entry_t e;
      logic [9:0] addrs [4];
      addrs[0] = 10'h010; addrs[1] = 10'd5; addrs[2] = 10'd7; addrs[3] = 10'd3;
      for (int i = 0; i < 4; i++) begin
         do_cycle(2'b11, 4'h0, 10'h0, 32'h0, 2'b11, 4'h0, addrs[i], 32'h0, 1'b0, 1'b1);
         if (i > 0) begin
            e = sb.pop_front();
            checks++;
            if (rf_b_rdata !== e.rf) begin errors++; $display("[TB] FAIL b2b_read%0d: got %h expected %h", i - 1, rf_b_rdata, e.rf); end
         end
      end
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_b_rdata !== e.rf) begin errors++; $display("[TB] FAIL b2b_read3: got %h expected %h", rf_b_rdata, e.rf); end
   endtask

   task automatic test_stall();
      sb_entry_t e;
      logic [31:0] held;
      logic [31:0] fresh;
      do_cycle(2'b11, 4'hF, 10'd1, 32'h0BADF00D, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      do_cycle(2'b11, 4'h0, 10'h010, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0);
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_a_rdata !== e.rf) begin errors++; $display("[TB] FAIL stall_pre: got %h expected %h", rf_a_rdata, e.rf); end
      held  = model[10'h010];
      fresh = model[10'd1];
      do_cycle(2'b01, 4'h0, 10'd1, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         if (i > 0) do_cycle(2'b00, 4'h0, 10'd1, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
         checks++;
         if (rf_a_rdata !== held) begin errors++; $display("[TB] FAIL stall_hold%0d: got %h expected %h", i, rf_a_rdata, held); end
      end
      do_cycle(2'b10, 4'h0, 10'h0, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      checks++;
      if (rf_a_rdata !== fresh) begin errors++; $display("[TB] FAIL stall_release: got %h expected %h", rf_a_rdata, fresh); end
   endtask

   task automatic test_reset_midflight();
      sb_entry_t e;
      do_cycle(2'b11, 4'h0, 10'd5, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      do_cycle(2'b11, 4'h0, 10'd7, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      aresetn = 1'b0;
      #1;
      checks++;
      if (rf_a_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midreset_rf: got %h expected 0", rf_a_rdata); end
      checks++;
      if (wf_a_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midreset_wf: got %h expected 0", wf_a_rdata); end
      @(posedge aclk);
      #1;
      aresetn = 1'b1;
      // Anything left in stage 0 would surface now if reset failed to clear it.
      idle_cycle();
      checks++;
      if (rf_a_rdata !== 32'h0) begin errors++; $display("[TB] FAIL midreset_flush: got %h expected 0", rf_a_rdata); end
      do_cycle(2'b11, 4'h0, 10'h010, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0);
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_a_rdata !== e.rf) begin errors++; $display("[TB] FAIL midreset_retained: got %h expected %h", rf_a_rdata, e.rf); end
   endtask

`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
   task automatic test_parity();
      sb_entry_t e;
      a_force = 4'b0100;
      do_cycle(2'b11, 4'hF, 10'h020, 32'hCAFEF00D, 2'b10, 4'h0, 10'h0, 32'h0, 1'b0, 1'b0);
      a_force = 4'b0000;
      do_cycle(2'b11, 4'h0, 10'h020, 32'h0, 2'b10, 4'h0, 10'h0, 32'h0, 1'b1, 1'b0);
      idle_cycle();
      e = sb.pop_front();
      checks++;
      if (rf_a_rdata !== e.rf) begin errors++; $display("[TB] FAIL parity_data: got %h expected %h", rf_a_rdata, e.rf); end
      checks++;
      if (rf_a_perr !== 4'b0100) begin errors++; $display("[TB] FAIL parity_forced: got %b expected 0100", rf_a_perr); end
   endtask
`endif

   // Test sequence
   initial begin
      checks  = 0;
      errors  = 0;
      aresetn = 1'b0;
      a_en = '0; a_we = '0; a_addr = '0; a_wdata = '0;
      b_en = '0; b_we = '0; b_addr = '0; b_wdata = '0;
`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
      a_force = '0;
      b_force = '0;
`endif
      foreach (model[i]) model[i] = 32'h0;
      $display("[TB] starting jelly3_bram_dualport_ram checks");
      test_reset();
      test_write_read();
      test_partial_write();
      test_collision();
      test_write_first();
      test_back_to_back();
      test_stall();
      test_reset_midflight();
`ifdef JELLY3_BRAM_DUALPORT_RAM_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
